// File: rtl/motion_pkg.sv
// Shared encodings and pure helper functions for the switch-driven motion mode sequencer.
// Holds the mode codes, direction classes, switch decoder and the transition rules used from RUN.
package motion_pkg;

  typedef enum logic [2:0] {
    MODE_STOP = 3'b000,
    MODE_R_1X = 3'b001,
    MODE_R_2X = 3'b010,
    MODE_L_1X = 3'b011,
    MODE_L_2X = 3'b100,
    MODE_FWD  = 3'b101,
    MODE_REV  = 3'b110
  } mode_t;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_F    = 3'd1,
    DIR_B    = 3'd2,
    DIR_R    = 3'd3,
    DIR_L    = 3'd4
  } dir_t;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_RAMP  = 2'd2;

  typedef struct packed {
    mode_t mode;
    logic  valid;
  } decode_t;

  typedef struct packed {
    mode_t      mode;
    logic [1:0] state;
  } step_t;

  // Switch code is {left_fwd, left_rev, right_fwd, right_rev}; undefined codes fall back to STOP.
  function automatic decode_t decode_code(input logic [3:0] code);
    decode_t d;
    d.mode  = MODE_STOP;
    d.valid = 1'b1;
    case (code)
      4'b0000:          d.mode = MODE_STOP;
      4'b1000, 4'b0001: d.mode = MODE_R_1X;
      4'b1001:          d.mode = MODE_R_2X;
      4'b0010, 4'b0100: d.mode = MODE_L_1X;
      4'b0110:          d.mode = MODE_L_2X;
      4'b1010:          d.mode = MODE_FWD;
      4'b0101:          d.mode = MODE_REV;
      default:          d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic dir_t dir_class(input mode_t mode);
    dir_t c;
    case (mode)
      MODE_FWD:             c = DIR_F;
      MODE_REV:             c = DIR_B;
      MODE_R_1X, MODE_R_2X: c = DIR_R;
      MODE_L_1X, MODE_L_2X: c = DIR_L;
      default:              c = DIR_NONE;
    endcase
    return c;
  endfunction

  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return ((a == DIR_F) && (b == DIR_B)) || ((a == DIR_B) && (b == DIR_F)) ||
           ((a == DIR_R) && (b == DIR_L)) || ((a == DIR_L) && (b == DIR_R));
  endfunction

  // Reversals go through a STOP guard; a 2X request from anything but the same side steps via 1X.
  function automatic step_t run_rules(input mode_t cur, input mode_t tgt);
    step_t s;
    s.mode  = tgt;
    s.state = ST_RUN;
    if (is_opposite(dir_class(tgt), dir_class(cur))) begin
      s.mode  = MODE_STOP;
      s.state = ST_GUARD;
    end else if ((tgt == MODE_R_2X) && (cur != MODE_R_1X) && (cur != MODE_R_2X)) begin
      s.mode  = MODE_R_1X;
      s.state = ST_RAMP;
    end else if ((tgt == MODE_L_2X) && (cur != MODE_L_1X) && (cur != MODE_L_2X)) begin
      s.mode  = MODE_L_1X;
      s.state = ST_RAMP;
    end
    return s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running sample strobe: counts 0..TC and raises tick while the count sits at TC.
// Dropping enable parks the counter at zero so the next tick is a full period away.
module tick_gen #(
  parameter int unsigned TC = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [W-1:0] TC_W = W'(TC);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == TC_W) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == TC_W);

endmodule

// File: rtl/motion_mode_sequencer.sv
// Turns the four wheel switches into a rojobot motion mode, debouncing on a slow tick and
// sequencing safe transitions (STOP guard on reversal, 1X step before 2X).
module motion_mode_sequencer
  import motion_pkg::*;
#(
  parameter bit          SIMULATE        = 1'b0,
  parameter int unsigned TICK_CNT_HW     = 19_999_999,
  parameter int unsigned TICK_CNT_SIM    = 5,
  parameter int unsigned DEBOUNCE_TICKS  = 2,
  parameter int unsigned REV_GUARD_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       left_fwd,
  input  logic       left_rev,
  input  logic       right_fwd,
  input  logic       right_rev,
  output logic [2:0] motion_mode,
  output logic       mode_changed,
  output logic       tick,
  output logic       illegal
);

  localparam int unsigned TC = SIMULATE ? TICK_CNT_SIM : TICK_CNT_HW;
  localparam int unsigned SW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned GW = $clog2(REV_GUARD_TICKS + 1);
  localparam logic [SW-1:0] DB_MAX    = SW'(DEBOUNCE_TICKS);
  localparam logic [GW-1:0] GUARD_MAX = GW'(REV_GUARD_TICKS);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    last_q, last_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [1:0]    state_q, state_d;
  mode_t         target_q, target_d;
  mode_t         mode_q, mode_d;
  mode_t         mode_prev_q;
  logic          mode_changed_q;
  logic          illegal_q, illegal_d;

  decode_t       dec;
  mode_t         tgt_now;
  step_t         step;
  logic          accept;

  tick_gen #(
    .TC(TC)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  // Debounce and FSM only advance on a tick; a freshly accepted code is acted on in the same tick.
  always_comb begin
    last_d     = last_q;
    stable_d   = stable_q;
    guard_d    = guard_q;
    state_d    = state_q;
    target_d   = target_q;
    mode_d     = mode_q;
    illegal_d  = 1'b0;
    accept     = 1'b0;
    dec        = decode_code(sync2_q);
    tgt_now    = target_q;
    step.mode  = mode_q;
    step.state = state_q;
    if (tick) begin
      last_d = sync2_q;
      if (sync2_q == last_q) begin
        stable_d = (stable_q == DB_MAX) ? stable_q : stable_q + SW'(1);
      end else begin
        stable_d = SW'(1);
      end
      accept    = (stable_d == DB_MAX);
      tgt_now   = accept ? dec.mode : target_q;
      target_d  = tgt_now;
      illegal_d = accept && !dec.valid;
      // RAMP completes through the run rules: same-side 1X to 2X is a direct move there.
      if ((state_q == ST_GUARD) && (guard_q != GUARD_MAX)) begin
        guard_d    = guard_q + GW'(1);
        step.mode  = MODE_STOP;
        step.state = ST_GUARD;
      end else begin
        step = run_rules(mode_q, tgt_now);
        if (step.state == ST_GUARD) begin
          guard_d = GW'(1);
        end
      end
      mode_d  = step.mode;
      state_d = step.state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      last_q         <= '0;
      stable_q       <= '0;
      guard_q        <= '0;
      state_q        <= ST_RUN;
      target_q       <= MODE_STOP;
      mode_q         <= MODE_STOP;
      mode_prev_q    <= MODE_STOP;
      mode_changed_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      sync1_q        <= {left_fwd, left_rev, right_fwd, right_rev};
      sync2_q        <= sync1_q;
      last_q         <= last_d;
      stable_q       <= stable_d;
      guard_q        <= guard_d;
      state_q        <= state_d;
      target_q       <= target_d;
      mode_q         <= mode_d;
      mode_prev_q    <= mode_q;
      mode_changed_q <= enable && (mode_q != mode_prev_q);
      illegal_q      <= illegal_d;
    end
  end

  assign motion_mode  = mode_q;
  assign mode_changed = mode_changed_q;
  assign illegal      = illegal_q;

endmodule
